imm_field_encoder: RTL and testbench
====================================

// Module: imm_field_encoder
// PURPOSE
//  Inverse of the decode-stage immediate extender: packs a 16-bit operand into
//  the immediate field of a 16-bit instruction template, selected by the same
//  4-bit imSrcSelect code, and flags whether the value is representable.
//  Sits in the instruction-build/loader path (test program generator, boot patcher)
//  feeding instruction memory; valid/ready in, 2-entry buffered valid/ready out.
// PARAMETERS
//  DEPTH      2    output buffer entries (fixed at 2; other values unsupported)
//  ERR_W      8    width of saturating range-error counter
// PORTS
//  clk              in   1   rising-edge clock
//  rst              in   1   synchronous, active-high reset
//  in_valid         in   1   request valid
//  in_ready         out  1   request accepted when in_valid & in_ready
//  in_sel           in   4   imSrcSelect code: [3]=1 signed, [2:0]=field form
//  in_template      in   16  instruction word; bits outside field pass through
//  in_imm           in   16  operand value to encode
//  out_valid        out  1   head entry valid
//  out_ready        in   1   consumer takes head when out_valid & out_ready
//  out_instruction  out  16  template with field replaced
//  out_fits         out  1   1 = value exactly representable in field
//  clr_err          in   1   clears err_count and err_sticky
//  err_count        out  ERR_W  number of pushed entries with fits=0, saturating
//  err_sticky       out  1   set on any pushed entry with fits=0
// BEHAVIOUR
//  Field map (sel[2:0]): 000 ins[7:0] W=8; 001 ins[3:0] W=4; 010 ins[4:0] W=5;
//   011 ins[10:0] W=11; 100 ins[4:2] W=3; 101 ins[4:2] shift count (unsigned only).
//  Unsigned (sel[3]=0) fits iff imm[15:W]==0. Signed fits iff imm[15:W-1] all equal.
//  Form 101 unsigned: imm 1..7 -> field=imm[2:0]; imm 8 -> field 000; else fits=0.
//  fits=0 (any form): out_instruction = in_template unchanged (field not written).
//  Illegal codes 1101, 1110, 1111, 0110, 0111: fits=0, template unchanged.
//  Invariant: if fits=1, extender(sel, out_instruction) == in_imm.
//  Encode is combinational on inputs; result pushed into a 2-entry FIFO.
//  in_ready = (count < 2), from registered count only; no push-through when full,
//   even if a pop occurs the same cycle.
//  Latency: accept in cycle N -> out_valid with result in N+1; 1 result/cycle
//   sustained while out_ready=1.
//  Simultaneous push+pop: count unchanged, order preserved (FIFO, no reorder).
//  out_instruction/out_fits hold stable while out_valid & !out_ready.
//  err_count += 1 on push with fits=0, saturates at 2^ERR_W-1; clr_err same cycle
//   as an increment -> result 0, sticky 0 (clear wins).
//  Reset: count=0, out_valid=0, in_ready=1 from first post-reset cycle,
//   out_instruction=0, out_fits=0, err_count=0, err_sticky=0; buffered entries
//   discarded, reset mid-transfer drops in-flight data without output.
// STRUCTURE
//  Shared package: IMM_SEL_* constants for the 4-bit codes (shared with the
//   decode-stage extender and control unit), IMM_SIGNED_BIT index.
//  Sub-module imm_field_pack: combinational (sel, template, imm) -> (instr, fits).
//  Top: FIFO pointers/count, handshakes, error counter.
// TESTING
//  sel=1000 imm=FFF6 tmpl=4800 -> 48F6 fits=1; imm=0080 -> 4800 fits=0, err 0->1.
//  sel=0101 tmpl=3000: imm=0008 -> 3000 fits=1; imm=0003 -> 300C; imm=0 -> fits=0.
//  sel=1011 imm=FC00 tmpl=1000 -> 1400 fits=1; sel=0011 imm=0800 -> fits=0.
//  out_ready=0, push 3 back-to-back: in_ready drops after 2nd accept, 3rd held;
//   release -> outputs in order, one per cycle, no loss/duplication.
//  Random sel/imm vs extender model: fits=1 results round-trip exactly; 300
//   errors -> err_count=255; clr_err coincident with error -> 0.
//  Assert rst with 2 entries buffered -> next cycle out_valid=0, in_ready=1.

Source files
------------

// File: rtl/imm_field_encoder_pkg.sv
`default_nettype none
//==============================================================================
// Module   : imm_field_encoder_pkg
// Brief    : Immediate-select codes, field forms and range helper shared by
//            the immediate encoder, decode-stage extender and control unit.
// Revision : 1.0 - initial release
//==============================================================================
package imm_field_encoder_pkg;

  typedef logic [15:0] word_t;

  // imSrcSelect: bit 3 selects sign extension, bits 2:0 select the field form
  localparam int IMM_SIGNED_BIT = 3;

  localparam logic [3:0] IMM_SEL_U8    = 4'b0000;
  localparam logic [3:0] IMM_SEL_U4    = 4'b0001;
  localparam logic [3:0] IMM_SEL_U5    = 4'b0010;
  localparam logic [3:0] IMM_SEL_U11   = 4'b0011;
  localparam logic [3:0] IMM_SEL_U3    = 4'b0100;
  localparam logic [3:0] IMM_SEL_SHAMT = 4'b0101;
  localparam logic [3:0] IMM_SEL_S8    = 4'b1000;
  localparam logic [3:0] IMM_SEL_S4    = 4'b1001;
  localparam logic [3:0] IMM_SEL_S5    = 4'b1010;
  localparam logic [3:0] IMM_SEL_S11   = 4'b1011;
  localparam logic [3:0] IMM_SEL_S3    = 4'b1100;

  localparam logic [2:0] IMM_FORM_LO8  = 3'b000;
  localparam logic [2:0] IMM_FORM_LO4  = 3'b001;
  localparam logic [2:0] IMM_FORM_LO5  = 3'b010;
  localparam logic [2:0] IMM_FORM_LO11 = 3'b011;
  localparam logic [2:0] IMM_FORM_MID3 = 3'b100;
  localparam logic [2:0] IMM_FORM_SHFT = 3'b101;

  typedef struct packed {
    word_t instr;
    logic  fits;
  } packResult_t;

  // Signed: every bit from W-1 upward must equal the sign; unsigned: bits W+ zero
  function automatic logic fitsInWidth(input word_t imm, input int unsigned w,
                                       input logic isSigned);
    logic signed [15:0] sImm;
    word_t              upper;
    sImm = $signed(imm);
    if (isSigned) begin
      upper = sImm >>> (w - 1);
      return (upper == '0) || (upper == '1);
    end
    return (imm >> w) == '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imm_field_encoder_if.sv
`default_nettype none
//==============================================================================
// Module   : imm_field_encoder_if
// Brief    : Request (valid/ready) and result (valid/ready) bus of the
//            immediate field encoder.
// Revision : 1.0 - initial release
//==============================================================================
interface imm_field_encoder_if;
  import imm_field_encoder_pkg::*;

  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_sel;
  word_t      in_template;
  word_t      in_imm;
  logic       out_valid;
  logic       out_ready;
  word_t      out_instruction;
  logic       out_fits;

  modport master (
    output in_valid, in_sel, in_template, in_imm, out_ready,
    input  in_ready, out_valid, out_instruction, out_fits
  );

  modport slave (
    input  in_valid, in_sel, in_template, in_imm, out_ready,
    output in_ready, out_valid, out_instruction, out_fits
  );
endinterface
`default_nettype wire

// File: rtl/imm_field_pack.sv
`default_nettype none
//==============================================================================
// Module   : imm_field_pack
// Brief    : Combinational insert of an operand into the immediate field
//            selected by imSrcSelect, with exact-representability flag.
// Revision : 1.0 - initial release
//==============================================================================
module imm_field_pack
  import imm_field_encoder_pkg::*;
(
  input  logic [3:0] i_sel,
  input  word_t      i_template,
  input  word_t      i_imm,
  output word_t      o_instr,
  output logic       o_fits
);

  logic w_isSigned;
  assign w_isSigned = i_sel[IMM_SIGNED_BIT];

  // A value that does not fit leaves the template untouched
  always_comb begin
    o_instr = i_template;
    o_fits  = 1'b0;
    case (i_sel[2:0])
      IMM_FORM_LO8: begin
        if (fitsInWidth(i_imm, 8, w_isSigned)) begin
          o_fits       = 1'b1;
          o_instr[7:0] = i_imm[7:0];
        end
      end
      IMM_FORM_LO4: begin
        if (fitsInWidth(i_imm, 4, w_isSigned)) begin
          o_fits       = 1'b1;
          o_instr[3:0] = i_imm[3:0];
        end
      end
      IMM_FORM_LO5: begin
        if (fitsInWidth(i_imm, 5, w_isSigned)) begin
          o_fits       = 1'b1;
          o_instr[4:0] = i_imm[4:0];
        end
      end
      IMM_FORM_LO11: begin
        if (fitsInWidth(i_imm, 11, w_isSigned)) begin
          o_fits        = 1'b1;
          o_instr[10:0] = i_imm[10:0];
        end
      end
      IMM_FORM_MID3: begin
        if (fitsInWidth(i_imm, 3, w_isSigned)) begin
          o_fits       = 1'b1;
          o_instr[4:2] = i_imm[2:0];
        end
      end
      IMM_FORM_SHFT: begin
        // Shift counts 1..8; a count of 8 is carried as field value 000
        if (!w_isSigned) begin
          if ((i_imm >= 16'd1) && (i_imm <= 16'd7)) begin
            o_fits       = 1'b1;
            o_instr[4:2] = i_imm[2:0];
          end else if (i_imm == 16'd8) begin
            o_fits       = 1'b1;
            o_instr[4:2] = 3'b000;
          end
        end
      end
      default: begin
        o_instr = i_template;
        o_fits  = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/imm_field_encoder.sv
`default_nettype none
//==============================================================================
// Module   : imm_field_encoder
// Brief    : Immediate field encoder with 2-entry result buffer and
//            saturating range-error counter.
// Revision : 1.0 - initial release
//==============================================================================
module imm_field_encoder
  import imm_field_encoder_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  imm_field_encoder_if.slave bus,
  input  logic             clr_err,
  output logic [ERR_W-1:0] err_count,
  output logic             err_sticky
);

  localparam logic [1:0]       c_FULL    = 2'(DEPTH);
  localparam logic [ERR_W-1:0] c_ERR_MAX = '1;

  word_t       w_packInstr;
  logic        w_packFits;
  logic        w_push;
  logic        w_pop;

  packResult_t r_mem [DEPTH];
  logic        r_wrPtr;
  logic        r_rdPtr;
  logic [1:0]  r_count;
  logic [ERR_W-1:0] r_errCount;
  logic        r_errSticky;

  imm_field_pack u_pack (
    .i_sel      (bus.in_sel),
    .i_template (bus.in_template),
    .i_imm      (bus.in_imm),
    .o_instr    (w_packInstr),
    .o_fits     (w_packFits)
  );

  // Ready comes only from the registered count: a full buffer refuses even
  // when the head is popped in the same cycle
  assign bus.in_ready        = (r_count < c_FULL);
  assign bus.out_valid       = (r_count != 2'd0);
  assign bus.out_instruction = r_mem[r_rdPtr].instr;
  assign bus.out_fits        = r_mem[r_rdPtr].fits;

  assign w_push = bus.in_valid && bus.in_ready;
  assign w_pop  = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= 1'b0;
      r_rdPtr <= 1'b0;
      r_count <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= '{instr: w_packInstr, fits: w_packFits};
        r_wrPtr        <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Clear takes priority over a coincident out-of-range push
  always_ff @(posedge clk) begin
    if (rst || clr_err) begin
      r_errCount  <= '0;
      r_errSticky <= 1'b0;
    end else if (w_push && !w_packFits) begin
      if (r_errCount != c_ERR_MAX) begin
        r_errCount <= r_errCount + 1'b1;
      end
      r_errSticky <= 1'b1;
    end
  end

  assign err_count  = r_errCount;
  assign err_sticky = r_errSticky;

endmodule
`default_nettype wire

// File: tb/tb_imm_field_encoder.sv
`default_nettype none
//==============================================================================
// Module   : tb_imm_field_encoder
// Brief    : Self-checking bench for imm_field_encoder against a range-based
//            encode/extend reference model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_imm_field_encoder;
  import imm_field_encoder_pkg::*;

  localparam int ERR_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             clr_err;
  logic [ERR_W-1:0] err_count;
  logic             err_sticky;
  int               checks = 0;
  int               errors = 0;

  typedef struct {
    logic [3:0]  sel;
    logic [15:0] imm;
    logic [15:0] instr;
    logic        fits;
  } exp_t;

  imm_field_encoder_if bus ();

  imm_field_encoder #(.DEPTH(2), .ERR_W(ERR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .clr_err    (clr_err),
    .err_count  (err_count),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  function automatic void fieldOf(input logic [2:0] form, output int lo, output int w);
    case (form)
      3'd0:    begin lo = 0; w = 8;  end
      3'd1:    begin lo = 0; w = 4;  end
      3'd2:    begin lo = 0; w = 5;  end
      3'd3:    begin lo = 0; w = 11; end
      3'd4:    begin lo = 2; w = 3;  end
      3'd5:    begin lo = 2; w = 3;  end
      default: begin lo = 0; w = 0;  end
    endcase
  endfunction

  // Reference encoder: numeric range test, then field insert by mask arithmetic
  function automatic void model(input logic [3:0] sel, input logic [15:0] tmpl,
                                input logic [15:0] imm, output logic [15:0] instr,
                                output logic fits);
    int lo, w, v, field, mask;
    instr = tmpl;
    fits  = 1'b0;
    field = 0;
    fieldOf(sel[2:0], lo, w);
    if (w == 0) return;
    if (sel[2:0] == 3'd5) begin
      if (sel[3]) return;
      if (int'(imm) >= 1 && int'(imm) <= 8) begin
        fits  = 1'b1;
        field = int'(imm) % 8;
      end else return;
    end else begin
      if (sel[3]) begin
        v    = int'($signed(imm));
        fits = (v >= -(1 << (w - 1))) && (v < (1 << (w - 1)));
      end else begin
        fits = int'(imm) < (1 << w);
      end
      if (!fits) return;
      field = int'(imm) % (1 << w);
    end
    mask  = (1 << w) - 1;
    instr = 16'((int'(tmpl) & ~(mask << lo)) | (field << lo));
  endfunction

  // Decode-stage extender model, used for round-trip checks
  function automatic logic [15:0] extend(input logic [3:0] sel, input logic [15:0] instr);
    int lo, w, field;
    fieldOf(sel[2:0], lo, w);
    field = (int'(instr) >> lo) % (1 << w);
    if (sel[2:0] == 3'd5) return (field == 0) ? 16'd8 : 16'(field);
    if (sel[3] && field >= (1 << (w - 1))) field = field - (1 << w);
    return 16'(field);
  endfunction

  task automatic do_reset();
    rst             = 1'b1;
    clr_err         = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_sel      = 4'd0;
    bus.in_template = 16'd0;
    bus.in_imm      = 16'd0;
    bus.out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send(input logic [3:0] sel, input logic [15:0] tmpl, input logic [15:0] imm);
    bus.in_valid    = 1'b1;
    bus.in_sel      = sel;
    bus.in_template = tmpl;
    bus.in_imm      = imm;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.out_instruction !== 16'h0000) begin errors++; $display("FAIL reset_instr got %h want 0000", bus.out_instruction); end
    checks++; if (bus.out_fits !== 1'b0) begin errors++; $display("FAIL reset_fits got %b want 0", bus.out_fits); end
    checks++; if (err_count !== 8'd0 || err_sticky !== 1'b0) begin errors++; $display("FAIL reset_err got %0d/%b want 0/0", err_count, err_sticky); end
  endtask

  task automatic test_signed8();
    send(4'b1000, 16'h4800, 16'hFFF6);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL s8_latency got valid %b want 1", bus.out_valid); end
    checks++; if (bus.out_instruction !== 16'h48F6 || bus.out_fits !== 1'b1) begin errors++; $display("FAIL s8_fit got %h/%b want 48F6/1", bus.out_instruction, bus.out_fits); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL s8_err0 got %0d want 0", err_count); end
    take();
    send(4'b1000, 16'h4800, 16'h0080);
    checks++; if (bus.out_instruction !== 16'h4800 || bus.out_fits !== 1'b0) begin errors++; $display("FAIL s8_range got %h/%b want 4800/0", bus.out_instruction, bus.out_fits); end
    checks++; if (err_count !== 8'd1 || err_sticky !== 1'b1) begin errors++; $display("FAIL s8_err1 got %0d/%b want 1/1", err_count, err_sticky); end
    take();
  endtask

  task automatic test_shamt();
    send(4'b0101, 16'h3000, 16'h0008);
    checks++; if (bus.out_instruction !== 16'h3000 || bus.out_fits !== 1'b1) begin errors++; $display("FAIL shamt8 got %h/%b want 3000/1", bus.out_instruction, bus.out_fits); end
    take();
    send(4'b0101, 16'h3000, 16'h0003);
    checks++; if (bus.out_instruction !== 16'h300C || bus.out_fits !== 1'b1) begin errors++; $display("FAIL shamt3 got %h/%b want 300C/1", bus.out_instruction, bus.out_fits); end
    take();
    send(4'b0101, 16'h3000, 16'h0000);
    checks++; if (bus.out_instruction !== 16'h3000 || bus.out_fits !== 1'b0) begin errors++; $display("FAIL shamt0 got %h/%b want 3000/0", bus.out_instruction, bus.out_fits); end
    take();
  endtask

  task automatic test_form11();
    send(4'b1011, 16'h1000, 16'hFC00);
    checks++; if (bus.out_instruction !== 16'h1400 || bus.out_fits !== 1'b1) begin errors++; $display("FAIL s11 got %h/%b want 1400/1", bus.out_instruction, bus.out_fits); end
    take();
    send(4'b0011, 16'h1000, 16'h0800);
    checks++; if (bus.out_instruction !== 16'h1000 || bus.out_fits !== 1'b0) begin errors++; $display("FAIL u11_range got %h/%b want 1000/0", bus.out_instruction, bus.out_fits); end
    take();
  endtask

  task automatic test_back_to_back();
    logic [3:0]  sel  [3] = '{4'b0000, 4'b0001, 4'b0010};
    logic [15:0] tmpl [3] = '{16'hAA00, 16'h1230, 16'hFFE0};
    logic [15:0] imm  [3] = '{16'h0011, 16'h0005, 16'h001F};
    logic [15:0] ei   [3];
    logic        ef   [3];
    int          got = 0;
    bit          cAcc = 0;
    for (int i = 0; i < 3; i++) model(sel[i], tmpl[i], imm[i], ei[i], ef[i]);
    do_reset();
    send(sel[0], tmpl[0], imm[0]);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got %b want 1", bus.in_ready); end
    send(sel[1], tmpl[1], imm[1]);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full got %b want 0", bus.in_ready); end
    bus.in_valid    = 1'b1;
    bus.in_sel      = sel[2];
    bus.in_template = tmpl[2];
    bus.in_imm      = imm[2];
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b0 || bus.out_instruction !== ei[0]) begin errors++; $display("FAIL b2b_hold got ready %b instr %h want 0 %h", bus.in_ready, bus.out_instruction, ei[0]); end
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 10 && got < 3; cyc++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_instruction !== ei[got] || bus.out_fits !== ef[got]) begin
        errors++; $display("FAIL b2b_order idx %0d got %b %h/%b want 1 %h/%b", got, bus.out_valid, bus.out_instruction, bus.out_fits, ei[got], ef[got]);
      end
      got++;
      if (bus.in_valid && bus.in_ready) cAcc = 1;
      @(posedge clk); #1;
      if (cAcc) bus.in_valid = 1'b0;
    end
    checks++; if (!cAcc || bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got accepted %b valid %b want 1 0", cAcc, bus.out_valid); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random();
    exp_t        q[$];
    exp_t        e;
    int          errM = 0;
    logic        stM = 1'b0;
    int          sizeBefore;
    logic [15:0] mi;
    logic        mf;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.in_valid    = ($urandom % 4) != 0;
      bus.in_sel      = 4'($urandom);
      bus.in_template = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       bus.in_imm = 16'($urandom);
        1:       bus.in_imm = 16'($urandom_range(0, 40));
        default: bus.in_imm = 16'(-int'($urandom_range(0, 40)));
      endcase
      bus.out_ready = ($urandom % 3) != 0;
      clr_err       = ($urandom % 50) == 0;
      #2;
      sizeBefore = q.size();
      checks++; if (bus.in_ready !== (sizeBefore < 2)) begin errors++; $display("FAIL rnd_in_ready cyc %0d got %b want %b", cyc, bus.in_ready, sizeBefore < 2); end
      checks++; if (bus.out_valid !== (sizeBefore != 0)) begin errors++; $display("FAIL rnd_out_valid cyc %0d got %b want %b", cyc, bus.out_valid, sizeBefore != 0); end
      checks++; if (err_count !== ERR_W'(errM) || err_sticky !== stM) begin errors++; $display("FAIL rnd_err cyc %0d got %0d/%b want %0d/%b", cyc, err_count, err_sticky, errM, stM); end
      if (sizeBefore != 0 && bus.out_ready) begin
        e = q.pop_front();
        checks++; if (bus.out_instruction !== e.instr || bus.out_fits !== e.fits) begin errors++; $display("FAIL rnd_data cyc %0d got %h/%b want %h/%b", cyc, bus.out_instruction, bus.out_fits, e.instr, e.fits); end
        if (e.fits) begin
          checks++; if (extend(e.sel, bus.out_instruction) !== e.imm) begin errors++; $display("FAIL rnd_roundtrip sel %b got %h want %h", e.sel, extend(e.sel, bus.out_instruction), e.imm); end
        end
      end
      if (bus.in_valid && sizeBefore < 2) begin
        model(bus.in_sel, bus.in_template, bus.in_imm, mi, mf);
        q.push_back('{sel: bus.in_sel, imm: bus.in_imm, instr: mi, fits: mf});
        if (!clr_err && !mf) begin
          if (errM < 255) errM++;
          stM = 1'b1;
        end
      end
      if (clr_err) begin
        errM = 0;
        stM  = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    clr_err      = 1'b0;
  endtask

  task automatic test_err_saturate();
    do_reset();
    bus.out_ready   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.in_sel      = 4'b0111;
    bus.in_template = 16'h5A5A;
    bus.in_imm      = 16'h0001;
    repeat (300) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    checks++; if (err_count !== 8'd255 || err_sticky !== 1'b1) begin errors++; $display("FAIL err_saturate got %0d/%b want 255/1", err_count, err_sticky); end
  endtask

  task automatic test_clr_coincident();
    bus.in_valid = 1'b1;
    clr_err      = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    checks++; if (err_count !== 8'd0 || err_sticky !== 1'b0) begin errors++; $display("FAIL clr_wins got %0d/%b want 0/0", err_count, err_sticky); end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    checks++; if (err_count !== 8'd1 || err_sticky !== 1'b1) begin errors++; $display("FAIL err_after_clr got %0d/%b want 1/1", err_count, err_sticky); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    send(4'b0000, 16'h1100, 16'h0022);
    send(4'b0001, 16'h2200, 16'h0003);
    checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_full got %b/%b want 1/0", bus.out_valid, bus.in_ready); end
    bus.in_valid = 1'b1;
    rst          = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_instruction !== 16'h0000) begin errors++; $display("FAIL mid_reset got %b/%b/%h want 0/1/0000", bus.out_valid, bus.in_ready, bus.out_instruction); end
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_dropped got %b want 0", bus.out_valid); end
  endtask

  initial begin
    test_reset();
    test_signed8();
    test_shamt();
    test_form11();
    test_back_to_back();
    test_random();
    test_err_saturate();
    test_clr_coincident();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
